// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: register-address
// geometry and the controller state encoding.
package mips_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
   localparam int unsigned SCNT_W = 4;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALL   = 2'd1,
      MD_BUSY = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_match.sv
// Source-operand match for one in-flight destination register; $zero never
// produces a dependency.
module hazard_match
   import mips_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] dest,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic                  uses_rt,
   output logic                  match_c
);

   assign match_c = (dest != REG_ZERO) && ((dest == rs) || (uses_rt && (dest == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, taken-branch
// flush, saturating stall counter. Mult/div interlock under MIPS_MULDIV_INTERLOCK_EN.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] IF_ID_rs,
   input  logic [REG_ADDR_W-1:0] IF_ID_rt,
   input  logic                  IF_ID_uses_rt,
   input  logic                  IF_ID_branch,
   input  logic                  IF_ID_muldiv,
   input  logic                  IF_ID_hilo_read,
   input  logic                  ID_EXE_reg_write,
   input  logic                  ID_EXE_mem_read,
   input  logic [REG_ADDR_W-1:0] ID_EXE_write_dest,
   input  logic                  EX_MEM_mem_read,
   input  logic [REG_ADDR_W-1:0] EX_MEM_write_dest,
   input  logic                  branch_taken,
   output logic                  pc_write,
   output logic                  IF_ID_write,
   output logic                  ID_EXE_bubble,
   output logic                  IF_ID_flush,
   output logic [CNT_W-1:0]      stall_cycles
);

   hz_state_e         state_q, state_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic [SCNT_W-1:0] mcnt_q, mcnt_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
   logic              id_hit_c, mem_hit_c;
   logic [1:0]        need_c;
   logic              stall_c, flush_c;

   hazard_match u_match_id_exe (
      .dest    (ID_EXE_write_dest),
      .rs      (IF_ID_rs),
      .rt      (IF_ID_rt),
      .uses_rt (IF_ID_uses_rt),
      .match_c (id_hit_c)
   );

   hazard_match u_match_ex_mem (
      .dest    (EX_MEM_write_dest),
      .rs      (IF_ID_rs),
      .rt      (IF_ID_rt),
      .uses_rt (IF_ID_uses_rt),
      .match_c (mem_hit_c)
   );

   // Required stall count: the two-cycle rule overrides any one-cycle rule
   always_comb begin
      need_c = 2'd0;
      if (ID_EXE_mem_read && id_hit_c)                                        need_c = 2'd1;
      if (IF_ID_branch && ID_EXE_reg_write && !ID_EXE_mem_read && id_hit_c)   need_c = 2'd1;
      if (IF_ID_branch && EX_MEM_mem_read && mem_hit_c)                       need_c = 2'd1;
      if (IF_ID_branch && ID_EXE_mem_read && id_hit_c)                        need_c = 2'd2;
   end

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      mcnt_d  = '0;
      stall_c = 1'b0;
      flush_c = 1'b0;
      case (state_q)
         RUN: begin
            if (need_c != 2'd0) begin
               stall_c = 1'b1;
               if (need_c == 2'd2) begin
                  state_d = STALL;
                  scnt_d  = SCNT_W'(1);
               end
            end else begin
               flush_c = IF_ID_branch && branch_taken;
`ifdef MIPS_MULDIV_INTERLOCK_EN
               if (IF_ID_muldiv) begin
                  state_d = MD_BUSY;
                  mcnt_d  = SCNT_W'(MULDIV_LAT);
               end
`endif
            end
         end
         STALL: begin
            stall_c = 1'b1;
            scnt_d  = (scnt_q != '0) ? scnt_q - SCNT_W'(1) : '0;
            if (scnt_q <= SCNT_W'(1)) state_d = RUN;
         end
`ifdef MIPS_MULDIV_INTERLOCK_EN
         MD_BUSY: begin
            mcnt_d = (mcnt_q != '0) ? mcnt_q - SCNT_W'(1) : '0;
            // A pending second load-branch stall runs down alongside the busy count
            if (scnt_q != '0) begin
               stall_c = 1'b1;
               scnt_d  = scnt_q - SCNT_W'(1);
            end else begin
               stall_c = (need_c != 2'd0);
               if (need_c == 2'd2) scnt_d = SCNT_W'(1);
            end
            if (IF_ID_muldiv || IF_ID_hilo_read) stall_c = 1'b1;
            if (mcnt_q <= SCNT_W'(1)) state_d = (scnt_d != '0) ? STALL : RUN;
         end
`endif
         default: state_d = RUN;
      endcase
      if (rst) begin
         stall_c = 1'b0;
         flush_c = 1'b0;
      end
   end

   assign stall_cycles_d = (stall_c && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1)
                                                           : stall_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         scnt_q         <= '0;
         mcnt_q         <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         scnt_q         <= scnt_d;
         mcnt_q         <= mcnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

`ifndef MIPS_MULDIV_INTERLOCK_EN
   logic unused_c;
   assign unused_c = ^{IF_ID_muldiv, IF_ID_hilo_read, mcnt_q, SCNT_W'(MULDIV_LAT)};
`endif

   assign pc_write      = !stall_c;
   assign IF_ID_write   = !stall_c;
   assign ID_EXE_bubble = stall_c;
   assign IF_ID_flush   = flush_c;
   assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// sequences and randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;

   localparam int unsigned TB_CNT_W = 3;
   localparam int unsigned TB_LAT   = 4;
   localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       branch;
      logic       taken;
      logic       muldiv;
      logic       hilo;
      logic       ie_rw;
      logic       ie_mr;
      logic [4:0] ie_dest;
      logic       em_mr;
      logic [4:0] em_dest;
   } in_t;

   typedef struct {
      in_t  in;
      logic exp_stall;
      logic exp_flush;
      int   exp_cnt;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [4:0]          IF_ID_rs, IF_ID_rt, ID_EXE_write_dest, EX_MEM_write_dest;
   logic                IF_ID_uses_rt, IF_ID_branch, IF_ID_muldiv, IF_ID_hilo_read;
   logic                ID_EXE_reg_write, ID_EXE_mem_read, EX_MEM_mem_read, branch_taken;
   logic                pc_write, IF_ID_write, ID_EXE_bubble, IF_ID_flush;
   logic [TB_CNT_W-1:0] stall_cycles;

   int n_chk = 0;
   int n_err = 0;
   int m_pend = 0;
   int m_busy = 0;
   int m_cnt  = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULDIV_LAT(TB_LAT), .CNT_W(TB_CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .IF_ID_rs          (IF_ID_rs),
      .IF_ID_rt          (IF_ID_rt),
      .IF_ID_uses_rt     (IF_ID_uses_rt),
      .IF_ID_branch      (IF_ID_branch),
      .IF_ID_muldiv      (IF_ID_muldiv),
      .IF_ID_hilo_read   (IF_ID_hilo_read),
      .ID_EXE_reg_write  (ID_EXE_reg_write),
      .ID_EXE_mem_read   (ID_EXE_mem_read),
      .ID_EXE_write_dest (ID_EXE_write_dest),
      .EX_MEM_mem_read   (EX_MEM_mem_read),
      .EX_MEM_write_dest (EX_MEM_write_dest),
      .branch_taken      (branch_taken),
      .pc_write          (pc_write),
      .IF_ID_write       (IF_ID_write),
      .ID_EXE_bubble     (ID_EXE_bubble),
      .IF_ID_flush       (IF_ID_flush),
      .stall_cycles      (stall_cycles)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit dep(input logic [4:0] d, input in_t i);
      return (d != 5'd0) && ((d == i.rs) || (i.uses_rt && (d == i.rt)));
   endfunction

   // Largest stall demanded by any applicable rule
   function automatic int need(input in_t i);
      int n = 0;
      if (i.ie_mr && dep(i.ie_dest, i) && n < 1)                          n = 1;
      if (i.branch && i.ie_rw && !i.ie_mr && dep(i.ie_dest, i) && n < 1)  n = 1;
      if (i.branch && i.em_mr && dep(i.em_dest, i) && n < 1)              n = 1;
      if (i.branch && i.ie_mr && dep(i.ie_dest, i))                       n = 2;
      return n;
   endfunction

   task automatic step(input in_t i, input logic r,
                       output logic a_stall, output logic a_flush, output int a_cnt);
      int   n, np, nb;
      logic e_stall, e_flush;
      IF_ID_rs = i.rs;             IF_ID_rt = i.rt;
      IF_ID_uses_rt = i.uses_rt;   IF_ID_branch = i.branch;
      branch_taken = i.taken;      IF_ID_muldiv = i.muldiv;
      IF_ID_hilo_read = i.hilo;    ID_EXE_reg_write = i.ie_rw;
      ID_EXE_mem_read = i.ie_mr;   ID_EXE_write_dest = i.ie_dest;
      EX_MEM_mem_read = i.em_mr;   EX_MEM_write_dest = i.em_dest;
      rst = r;
      @(negedge clk);
      e_stall = 1'b0;
      e_flush = 1'b0;
      np = m_pend;
      nb = m_busy;
      if (!r) begin
         n = need(i);
         if (m_pend > 0) begin
            e_stall = 1'b1;
            np = m_pend - 1;
         end else begin
            e_stall = (n > 0);
            np = (n == 2) ? 1 : 0;
            if (m_busy == 0) e_flush = (n == 0) && i.branch && i.taken;
         end
         if (m_busy > 0) begin
            if (i.muldiv || i.hilo) e_stall = 1'b1;
            nb = m_busy - 1;
         end
`ifdef MIPS_MULDIV_INTERLOCK_EN
         else if (m_pend == 0 && n == 0 && i.muldiv) nb = TB_LAT;
`endif
      end
      a_stall = !pc_write;
      a_flush = IF_ID_flush;
      a_cnt   = int'(stall_cycles);
      chk("mdl_outputs", int'({pc_write, IF_ID_write, ID_EXE_bubble, IF_ID_flush}),
          int'({!e_stall, !e_stall, e_stall, e_flush}));
      chk("mdl_stall_cycles", a_cnt, m_cnt);
      if (r) begin
         m_pend = 0;
         m_busy = 0;
         m_cnt  = 0;
      end else begin
         m_pend = np;
         m_busy = nb;
         if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[12];
   in_t  nop, t;
   logic s, f;
   int   c;

   task automatic do_reset();
      logic rs_s, rs_f;
      int   rs_c;
      step(nop, 1'b1, rs_s, rs_f, rs_c);
      step(nop, 1'b1, rs_s, rs_f, rs_c);
      chk("reset_stall", int'(rs_s), 0);
      chk("reset_flush", int'(rs_f), 0);
   endtask

   initial begin
      nop = '0;
      for (int k = 0; k < 12; k++) tbl[k] = '{in: nop, exp_stall: 1'b0, exp_flush: 1'b0, exp_cnt: 0};
      tbl[1].in  = '{rs: 5'd8, ie_mr: 1'b1, ie_dest: 5'd8, default: '0};
      tbl[1].exp_stall = 1'b1;
      tbl[2].exp_cnt = 1;
      tbl[3].in  = '{rs: 5'd0, ie_mr: 1'b1, ie_dest: 5'd0, default: '0};
      tbl[3].exp_cnt = 1;
      tbl[4].in  = '{rs: 5'd3, branch: 1'b1, taken: 1'b1, ie_rw: 1'b1, ie_dest: 5'd5, default: '0};
      tbl[4].exp_flush = 1'b1;  tbl[4].exp_cnt = 1;
      tbl[5].in  = '{rs: 5'd5, branch: 1'b1, taken: 1'b1, ie_rw: 1'b1, ie_dest: 5'd5, default: '0};
      tbl[5].exp_stall = 1'b1;  tbl[5].exp_cnt = 1;
      tbl[6].in  = '{rs: 5'd1, rt: 5'd7, ie_mr: 1'b1, ie_dest: 5'd7, default: '0};
      tbl[6].exp_cnt = 2;
      tbl[7].in  = '{rs: 5'd1, rt: 5'd7, uses_rt: 1'b1, ie_mr: 1'b1, ie_dest: 5'd7, default: '0};
      tbl[7].exp_stall = 1'b1;  tbl[7].exp_cnt = 2;
      tbl[8].in  = '{rs: 5'd4, branch: 1'b1, em_mr: 1'b1, em_dest: 5'd4, default: '0};
      tbl[8].exp_stall = 1'b1;  tbl[8].exp_cnt = 3;
      tbl[9].in  = '{rs: 5'd4, em_mr: 1'b1, em_dest: 5'd4, default: '0};
      tbl[9].exp_cnt = 4;
      tbl[10].in = '{rs: 5'd2, branch: 1'b1, default: '0};
      tbl[10].exp_cnt = 4;
      tbl[11].exp_cnt = 4;

      do_reset();
      chk("reset_cnt", int'(stall_cycles), 0);
      for (int k = 0; k < 12; k++) begin
         step(tbl[k].in, 1'b0, s, f, c);
         chk($sformatf("vec%0d_stall", k), int'(s), int'(tbl[k].exp_stall));
         chk($sformatf("vec%0d_flush", k), int'(f), int'(tbl[k].exp_flush));
         chk($sformatf("vec%0d_cnt", k), c, tbl[k].exp_cnt);
      end

      // Branch on a load still in EX: two stalls, no re-evaluation inside STALL
      do_reset();
      t = '{rt: 5'd9, uses_rt: 1'b1, branch: 1'b1, ie_mr: 1'b1, ie_dest: 5'd9, default: '0};
      step(t, 1'b0, s, f, c);   chk("ldbr_c1_stall", int'(s), 1);
      step(t, 1'b0, s, f, c);   chk("ldbr_c2_stall", int'(s), 1);
      step(nop, 1'b0, s, f, c); chk("ldbr_c3_stall", int'(s), 0);
      chk("ldbr_cnt", c, 2);

      // Reset during the STALL cycle drops the remaining stall and the count
      do_reset();
      step(t, 1'b0, s, f, c);   chk("rst_mid_c1_stall", int'(s), 1);
      step(t, 1'b1, s, f, c);   chk("rst_mid_c2_stall", int'(s), 0);
      step(nop, 1'b0, s, f, c); chk("rst_mid_c3_stall", int'(s), 0);
      chk("rst_mid_cnt", c, 0);

      // Mult followed by a dependent mfhi
      do_reset();
      step('{muldiv: 1'b1, default: '0}, 1'b0, s, f, c);
      chk("md_issue_stall", int'(s), 0);
`ifdef MIPS_MULDIV_INTERLOCK_EN
      for (int k = 0; k < int'(TB_LAT); k++) begin
         step('{hilo: 1'b1, default: '0}, 1'b0, s, f, c);
         chk($sformatf("md_busy%0d_stall", k), int'(s), 1);
      end
`endif
      step('{hilo: 1'b1, default: '0}, 1'b0, s, f, c);
      chk("md_free_stall", int'(s), 0);

      // Stall counter saturation at all-ones
      do_reset();
      t = '{rs: 5'd8, ie_mr: 1'b1, ie_dest: 5'd8, default: '0};
      for (int k = 0; k < CNT_MAX + 3; k++) step(t, 1'b0, s, f, c);
      step(nop, 1'b0, s, f, c);
      chk("sat_cnt", c, CNT_MAX);

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         t.rs      = 5'($urandom_range(0, 3));
         t.rt      = 5'($urandom_range(0, 3));
         t.uses_rt = 1'($urandom_range(0, 1));
         t.branch  = 1'($urandom_range(0, 1));
         t.taken   = 1'($urandom_range(0, 1));
         t.muldiv  = ($urandom_range(0, 7) == 0);
         t.hilo    = ($urandom_range(0, 3) == 0);
         t.ie_rw   = 1'($urandom_range(0, 1));
         t.ie_mr   = 1'($urandom_range(0, 1));
         t.ie_dest = 5'($urandom_range(0, 3));
         t.em_mr   = 1'($urandom_range(0, 1));
         t.em_dest = 5'($urandom_range(0, 3));
         step(t, ($urandom_range(0, 31) == 0), s, f, c);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
